fifo_rd_logic: RTL and testbench

Read-side control for a dual-clock asynchronous FIFO. It keeps the read pointer in binary and Gray form, drives the RAM read address and read enable, and produces a registered empty flag. Empty is computed by comparing the next Gray read pointer against the write pointer, which is already synchronized into the read clock domain. The block sits between the FIFO storage array and the read-clock consumer, alongside a two-flop synchronizer that supplies `rq2_waddr`.

---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_rd_logic_if.sv | 32 +++
 rtl/fifo_rd_logic_bin2gray.sv | 13 +
 rtl/fifo_rd_logic.sv | 50 +++++
 tb/tb_fifo_rd_logic.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer definitions for the async FIFO read side, write side and synchronizers.
package fifo_pkg;

    localparam int PTR_SZ_DFLT = 4;

    // Pointer carries one extra wrap bit above the RAM address.
    typedef logic [PTR_SZ_DFLT:0] ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_rd_logic_if.sv
// Read-side handshake between the FIFO read controller and its consumer / sync.
interface fifo_rd_logic_if #(
    parameter int PTR_SZ = 4
);

    logic              rinc;
    logic [PTR_SZ:0]   rq2_waddr;
    logic              rempty;
    logic              read_en;
    logic [PTR_SZ-1:0] raddr;
    logic [PTR_SZ:0]   raddr_gray;

    // Consumer side: requests reads, supplies the synchronized write pointer.
    modport master (
        output rinc,
        output rq2_waddr,
        input  rempty,
        input  read_en,
        input  raddr,
        input  raddr_gray
    );

    modport slave (
        input  rinc,
        input  rq2_waddr,
        output rempty,
        output read_en,
        output raddr,
        output raddr_gray
    );

endinterface : fifo_rd_logic_if

// File: rtl/fifo_rd_logic_bin2gray.sv
// Binary to Gray conversion for FIFO pointers.
// Latency: combinational.
// Backpressure: none.
module bin2gray #(
    parameter int W = 5
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    assign gray = (bin >> 1) ^ bin;

endmodule : bin2gray

// File: rtl/fifo_rd_logic.sv
// Async FIFO read-side control: read pointer (binary + Gray), RAM address, registered empty.
// Latency: read_en combinational; raddr/raddr_gray/rempty one cycle after a qualified read.
// Backpressure: reads are ignored while rempty=1; rempty asserts on the edge that takes the last word.
module fifo_rd_logic
    import fifo_pkg::*;
#(
    parameter int PTR_SZ = PTR_SZ_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    fifo_rd_logic_if.slave   rd
);

    logic [PTR_SZ:0] rbin;
    logic [PTR_SZ:0] rbin_next;
    logic [PTR_SZ:0] rgray;
    logic [PTR_SZ:0] rgray_next;
    logic            rempty_q;
    logic            read_en;

    assign read_en   = rd.rinc & ~rempty_q;
    // Wrap bit rolls over naturally modulo 2^(PTR_SZ+1).
    assign rbin_next = rbin + {{PTR_SZ{1'b0}}, read_en};

    bin2gray #(
        .W (PTR_SZ + 1)
    ) u_rd_bin2gray (
        .bin  (rbin_next),
        .gray (rgray_next)
    );

    // Empty compares the post-read pointer so the last read flags empty on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbin     <= '0;
            rgray    <= '0;
            rempty_q <= 1'b1;
        end else begin
            rbin     <= rbin_next;
            rgray    <= rgray_next;
            rempty_q <= (rgray_next == rd.rq2_waddr);
        end
    end

    assign rd.read_en    = read_en;
    assign rd.rempty     = rempty_q;
    assign rd.raddr      = rbin[PTR_SZ-1:0];
    assign rd.raddr_gray = rgray;

endmodule : fifo_rd_logic

// File: tb/tb_fifo_rd_logic.sv
// Randomized + directed check of fifo_rd_logic against a pointer-count reference model (PTR_SZ=2).
module tb_fifo_rd_logic;

    localparam int PSZ = 2;
    localparam int PMOD = 1 << (PSZ + 1);

    logic clk;
    logic rst;

    fifo_rd_logic_if #(.PTR_SZ(PSZ)) rd_if ();

    fifo_rd_logic #(.PTR_SZ(PSZ)) dut (
        .clk (clk),
        .rst (rst),
        .rd  (rd_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Reference model: number of words read (mod 2^(PSZ+1)) and the empty flag.
    int m_rd;
    bit m_empty;
    int w_cnt;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_gray(input int x);
        return (x >> 1) ^ x;
    endfunction

    // One clock: drive inputs at negedge, check read_en, advance model, check registered outputs.
    task automatic step(input bit inc, input int w);
        bit take;
        @(negedge clk);
        rd_if.rinc      = inc;
        rd_if.rq2_waddr = 3'(to_gray(w % PMOD));
        #1;
        take = inc && !m_empty;
        chk("read_en", int'(rd_if.read_en), int'(take));
        @(posedge clk);
        if (take) m_rd = (m_rd + 1) % PMOD;
        m_empty = (m_rd == (w % PMOD));
        #1;
        chk("raddr", int'(rd_if.raddr), m_rd % (1 << PSZ));
        chk("raddr_gray", int'(rd_if.raddr_gray), to_gray(m_rd));
        chk("rempty", int'(rd_if.rempty), int'(m_empty));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_raddr"}, int'(rd_if.raddr), 0);
        chk({tag, "_raddr_gray"}, int'(rd_if.raddr_gray), 0);
        chk({tag, "_rempty"}, int'(rd_if.rempty), 1);
        chk({tag, "_read_en"}, int'(rd_if.read_en), 0);
    endtask

    int exp_fill_ra[3]  = '{1, 2, 3};
    int exp_fill_gr[3]  = '{1, 3, 2};
    int exp_wrap_ra[5]  = '{0, 1, 2, 3, 0};
    int exp_wrap_gr[5]  = '{6, 7, 5, 4, 0};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_rd = 0;
        m_empty = 1'b1;
        w_cnt = 0;

        // Reset held with a pending read request.
        rst = 1'b0;
        rd_if.rinc = 1'b1;
        rd_if.rq2_waddr = '0;
        #23;
        chk_reset_outputs("reset");

        // Fill then drain: write pointer at 3 (gray 2).
        @(negedge clk);
        rst = 1'b0;
        w_cnt = 3;
        rd_if.rq2_waddr = 3'(to_gray(w_cnt));
        rst = 1'b1;
        step(1'b0, w_cnt);
        chk("fill_not_empty", int'(rd_if.rempty), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, w_cnt);
            chk("fill_raddr_tbl", int'(rd_if.raddr), exp_fill_ra[i]);
            chk("fill_gray_tbl", int'(rd_if.raddr_gray), exp_fill_gr[i]);
        end
        chk("drain_empty", int'(rd_if.rempty), 1);

        // Reads while empty are ignored.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, w_cnt);
            chk("empty_hold_raddr", int'(rd_if.raddr), 3);
            chk("empty_hold_gray", int'(rd_if.raddr_gray), 2);
        end

        // Wrap-around: write pointer at 8 (gray 0).
        w_cnt = 8;
        step(1'b0, w_cnt);
        chk("wrap_not_empty", int'(rd_if.rempty), 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, w_cnt);
            chk("wrap_raddr_tbl", int'(rd_if.raddr), exp_wrap_ra[i]);
            chk("wrap_gray_tbl", int'(rd_if.raddr_gray), exp_wrap_gr[i]);
        end
        chk("wrap_empty", int'(rd_if.rempty), 1);

        // Random traffic: writer advances while occupancy stays within the depth.
        for (int i = 0; i < 300; i++) begin
            if (($urandom_range(0, 2) != 0) && (((w_cnt - m_rd) % PMOD + PMOD) % PMOD < (1 << PSZ)))
                w_cnt++;
            step(1'($urandom_range(0, 1)), w_cnt);
        end

        // Mid-run async reset while non-empty.
        w_cnt = m_rd + 2;
        step(1'b0, w_cnt);
        step(1'b1, w_cnt);
        @(posedge clk);
        #2;
        rd_if.rinc = 1'b1;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        m_rd = 0;
        m_empty = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        w_cnt = 1;
        step(1'b0, w_cnt);
        step(1'b1, w_cnt);
        step(1'b1, w_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fifo_rd_logic
